// File: rtl/manch_pkg.sv
// -----------------------------------------------------------------------------
// manch_pkg
// Shared types, line-coding constants and timing-window helpers for the
// Manchester decoder (manchester_decoder_mealy) and its edge front end.
// Optional feature macro used by the decoder: MANCH_DEC_GLITCH_FILTER_EN.
// -----------------------------------------------------------------------------
package manch_pkg;

  // Decoder state: searching for a mid-bit edge pair, or tracking mid-bit edges.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } manch_state_e;

  // Bit 0 is "01" (rising mid-bit edge); the line rests low between frames.
  localparam logic BIT0_MID_RISE = 1'b1;
  localparam logic IDLE_LEVEL    = 1'b0;

  // Edge one half-bit after the reference edge (a bit-boundary edge).
  function automatic logic in_win_b(input int unsigned cnt,
                                    input int unsigned ovs,
                                    input int unsigned tol);
    return (cnt >= (ovs - tol)) && (cnt <= (ovs + tol));
  endfunction

  // Edge one full bit after the reference edge (the next mid-bit edge).
  function automatic logic in_win_m(input int unsigned cnt,
                                    input int unsigned ovs,
                                    input int unsigned tol);
    return (cnt >= ((2 * ovs) - tol)) && (cnt <= ((2 * ovs) + tol));
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/manch_edge_sync.sv
// -----------------------------------------------------------------------------
// manch_edge_sync
// Brings the asynchronous Manchester line into the clock domain and flags
// level changes on it.
//   MANCH_DEC_GLITCH_FILTER_EN defined  : a registered 2-of-3 majority over the
//     last three synchronised samples feeds the edge detector; single-cycle
//     glitches vanish and the edge appears 2 cycles later.
//   MANCH_DEC_GLITCH_FILTER_EN undefined: the second synchroniser flop feeds the
//     edge detector directly.
// Ports:
//   i_clk    decoder clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_line   raw serial line
//   o_edge   level changed between the two most recent samples
//   o_rise   that change was low-to-high
// -----------------------------------------------------------------------------
module manch_edge_sync
  import manch_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_edge,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

`ifdef MANCH_DEC_GLITCH_FILTER_EN
  logic r_s4;
  logic r_flt;
  logic r_flt_d;

  // Synchroniser, sample history and registered majority filter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1    <= IDLE_LEVEL;
      r_s2    <= IDLE_LEVEL;
      r_s3    <= IDLE_LEVEL;
      r_s4    <= IDLE_LEVEL;
      r_flt   <= IDLE_LEVEL;
      r_flt_d <= IDLE_LEVEL;
    end else begin
      r_s1    <= i_line;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_s4    <= r_s3;
      r_flt   <= maj3(r_s2, r_s3, r_s4);
      r_flt_d <= r_flt;
    end
  end

  assign o_edge = r_flt ^ r_flt_d;
  assign o_rise = r_flt & ~r_flt_d;
`else
  // Two-flop synchroniser plus one sample of history for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= IDLE_LEVEL;
      r_s2 <= IDLE_LEVEL;
      r_s3 <= IDLE_LEVEL;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 ^ r_s3;
  assign o_rise = r_s2 & ~r_s3;
`endif

endmodule

// File: rtl/manchester_decoder_mealy.sv
// -----------------------------------------------------------------------------
// manchester_decoder_mealy
// Oversampling Manchester receiver. Measures the interval between line edges,
// locks once two edges one bit period apart are seen, then emits one NRZ bit
// per mid-bit edge. Boundary edges (half a bit after a mid edge) are ignored;
// any other interval while locked is a coding error. A silent line for longer
// than one bit period plus tolerance ends the frame.
// Optional feature macro: MANCH_DEC_GLITCH_FILTER_EN (see manch_edge_sync).
// Parameters:
//   OVS  clock cycles per half-bit, 4..64
//   TOL  edge timing tolerance in cycles, 0 <= TOL < OVS/2
// Ports:
//   clock      decoder clock, rising edge
//   reset_b    synchronous active-low reset
//   line_in    Manchester line, unsynchronised
//   bit_out    recovered bit, valid when bit_valid is high; held otherwise
//   bit_valid  one-cycle strobe per recovered bit
//   locked     high while tracking mid-bit edges
//   code_err   one-cycle strobe on an illegal edge interval while locked
// -----------------------------------------------------------------------------
module manchester_decoder_mealy
  import manch_pkg::*;
#(
  parameter int unsigned OVS = 4,
  parameter int unsigned TOL = 1
) (
  input  logic clock,
  input  logic reset_b,
  input  logic line_in,
  output logic bit_out,
  output logic bit_valid,
  output logic locked,
  output logic code_err
);

  localparam int unsigned CNT_MAX = 4 * OVS;
  localparam int unsigned CW      = $clog2(4 * OVS + 1);
  localparam int unsigned EOF_CNT = 2 * OVS + TOL + 1;

  manch_state_e   r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_have_edge;
  logic           r_bit_out;
  logic           r_bit_valid;
  logic           r_locked;
  logic           r_code_err;

  manch_state_e   w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CW-1:0]  w_cnt_now;
  logic           w_have_edge_nxt;
  logic           w_bit_nxt;
  logic           w_valid_nxt;
  logic           w_err_nxt;
  logic           w_edge;
  logic           w_rise;
  logic           w_bit;
  logic           w_in_b;
  logic           w_in_m;

  manch_edge_sync u_edge_sync (
    .i_clk   (clock),
    .i_rst_n (reset_b),
    .i_line  (line_in),
    .o_edge  (w_edge),
    .o_rise  (w_rise)
  );

  // r_cnt is cleared in the cycle of a reference edge, so the elapsed cycle
  // count seen by an edge in the current cycle is r_cnt + 1 (saturating).
  assign w_cnt_now = (r_cnt == CW'(CNT_MAX)) ? r_cnt : (r_cnt + CW'(1));
  assign w_in_b    = in_win_b(32'(w_cnt_now), OVS, TOL);
  assign w_in_m    = in_win_m(32'(w_cnt_now), OVS, TOL);
  assign w_bit     = w_rise ^ BIT0_MID_RISE;

  // Next-state, interval counter and strobe decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_now;
    w_have_edge_nxt = r_have_edge;
    w_bit_nxt       = r_bit_out;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_edge) begin
          w_cnt_nxt       = '0;
          w_have_edge_nxt = 1'b1;
          // Two edges a bit period apart must both be mid-bit edges.
          if (r_have_edge && w_in_m) begin
            w_state_nxt = LOCKED;
            w_valid_nxt = 1'b1;
            w_bit_nxt   = w_bit;
          end else begin
            w_state_nxt = HUNT;
          end
        end else if (w_cnt_now == CW'(CNT_MAX)) begin
          w_have_edge_nxt = 1'b0;
        end else begin
          w_have_edge_nxt = r_have_edge;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          if (w_in_b) begin
            // Boundary edge: keep timing from the previous mid-bit edge.
            w_cnt_nxt = w_cnt_now;
          end else if (w_in_m) begin
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_bit_nxt   = w_bit;
          end else begin
            // Bad interval; the offending edge seeds the next lock search.
            w_cnt_nxt       = '0;
            w_err_nxt       = 1'b1;
            w_state_nxt     = HUNT;
            w_have_edge_nxt = 1'b1;
          end
        end else if (w_cnt_now == CW'(EOF_CNT)) begin
          w_state_nxt     = HUNT;
          w_have_edge_nxt = 1'b0;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt     = HUNT;
        w_cnt_nxt       = '0;
        w_have_edge_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_have_edge <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_code_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_have_edge <= w_have_edge_nxt;
      r_bit_out   <= w_bit_nxt;
      r_bit_valid <= w_valid_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_code_err  <= w_err_nxt;
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign locked    = r_locked;
  assign code_err  = r_code_err;

endmodule

// File: tb/tb_manchester_decoder_mealy.sv
// -----------------------------------------------------------------------------
// tb_manchester_decoder_mealy
// Drives line_in one value per clock, keeps a timestamp-based reference model
// of the decoder and compares all outputs every cycle, plus directed counts of
// recovered bits and coding errors for the named scenarios.
// -----------------------------------------------------------------------------
module tb_manchester_decoder_mealy;

  localparam int OVS = 4;
  localparam int TOL = 1;

  logic clock = 1'b0;
  logic reset_b;
  logic line_in;
  logic bit_out;
  logic bit_valid;
  logic locked;
  logic code_err;

  always #5 clock = ~clock;

  manchester_decoder_mealy #(.OVS(OVS), .TOL(TOL)) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .line_in   (line_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .locked    (locked),
    .code_err  (code_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: line history, absolute cycle stamps, lock flag.
  logic       h [8];
  int         cyc;
  int         t_ref;
  bit         m_ref_ok;
  bit         m_locked;
  logic       m_bit_out;
  logic [3:0] exp_vec;
  logic       last_v;

  logic       obs_bits [$];
  int         n_err_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a + b + c) >= 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) h[k] = 1'b0;
    m_ref_ok  = 1'b0;
    m_locked  = 1'b0;
    m_bit_out = 1'b0;
    exp_vec   = 4'b0000;
  endtask

  // Predict outputs after the next rising edge, given the value just driven.
  task automatic model_step(input logic v);
    logic cur, prev, ev, rs, valid, err;
    int   el;
    bit   in_b, in_m;
    for (int k = 7; k > 0; k--) h[k] = h[k-1];
    h[0] = v;
    cyc++;
`ifdef MANCH_DEC_GLITCH_FILTER_EN
    cur  = maj(h[3], h[4], h[5]);
    prev = maj(h[4], h[5], h[6]);
`else
    cur  = h[2];
    prev = h[3];
`endif
    ev    = cur ^ prev;
    rs    = cur & ~prev;
    el    = cyc - t_ref;
    in_b  = m_ref_ok && (el >= OVS - TOL) && (el <= OVS + TOL);
    in_m  = m_ref_ok && (el >= 2*OVS - TOL) && (el <= 2*OVS + TOL);
    valid = 1'b0;
    err   = 1'b0;
    if (!m_locked) begin
      if (ev) begin
        if (in_m) begin
          m_locked  = 1'b1;
          valid     = 1'b1;
          m_bit_out = ~rs;
        end
        m_ref_ok = 1'b1;
        t_ref    = cyc;
      end
    end else begin
      if (ev) begin
        if (in_b) begin
          // boundary edge, nothing changes
        end else if (in_m) begin
          valid     = 1'b1;
          m_bit_out = ~rs;
          t_ref     = cyc;
        end else begin
          err      = 1'b1;
          m_locked = 1'b0;
          m_ref_ok = 1'b1;
          t_ref    = cyc;
        end
      end else if (el == 2*OVS + TOL + 1) begin
        m_locked = 1'b0;
        m_ref_ok = 1'b0;
      end
    end
    exp_vec = {m_locked, valid, m_bit_out, err};
  endtask

  // One clock: check last edge's outputs, then drive the next line value.
  task automatic step(input logic v, input logic rb);
    @(negedge clock);
    check_eq("outputs{locked,valid,bit,err}",
             {28'd0, locked, bit_valid, bit_out, code_err}, {28'd0, exp_vec});
    if (bit_valid === 1'b1) obs_bits.push_back(bit_out);
    if (code_err === 1'b1) n_err_seen++;
    line_in = v;
    reset_b = rb;
    last_v  = v;
    if (!rb) model_reset();
    else     model_step(v);
  endtask

  task automatic send_half(input logic lvl, input int n);
    repeat (n) step(lvl, 1'b1);
  endtask

  task automatic send_bit_j(input logic b, input int n1, input int n2);
    send_half(b, n1);
    send_half(~b, n2);
  endtask

  task automatic send_bit(input logic b);
    send_bit_j(b, OVS, OVS);
  endtask

  task automatic idle(input int n);
    send_half(1'b0, n);
  endtask

  function automatic logic [31:0] pack_bits();
    logic [31:0] p = 32'd0;
    foreach (obs_bits[i]) p = {p[30:0], obs_bits[i]};
    return p;
  endfunction

  function automatic int jit();
    int unsigned r = $urandom_range(0, 99);
    if (r < 70) return OVS;
    else if (r < 85) return OVS - 1;
    else return OVS + 1;
  endfunction

  initial begin
    cyc   = 0;
    t_ref = 0;
    reset_b = 1'b0;
    line_in = 1'b0;
    last_v  = 1'b0;
    n_err_seen = 0;
    model_reset();
    repeat (3) @(posedge clock);

    // Reset held with a toggling line: outputs stay 0.
    for (int i = 0; i < 8; i++) step(1'(i & 1), 1'b0);
    step(1'b0, 1'b0);
    idle(12);
    check_eq("reset_unlocked", {31'd0, locked}, 32'd0);

    // 0,1,0,1,1,0 from idle: bits 1,0,1,1,0 recovered, then end of frame.
    obs_bits.delete();
    n_err_seen = 0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle(20);
    check_eq("s_basic_count", 32'(obs_bits.size()), 32'd5);
    check_eq("s_basic_bits", pack_bits(), 32'b10110);
    check_eq("s_basic_no_err", 32'(n_err_seen), 32'd0);
    check_eq("s_basic_eof", {31'd0, locked}, 32'd0);

    // 1,1,1,1: edges every half bit, no lock; then a 0 locks.
    obs_bits.delete();
    repeat (4) send_bit(1'b1);
    check_eq("s_ones_no_bits", 32'(obs_bits.size()), 32'd0);
    check_eq("s_ones_hunt", {31'd0, locked}, 32'd0);
    send_bit(1'b0);
    check_eq("s_ones_then0_lock", {31'd0, locked}, 32'd1);
    idle(20);

    // Edge at cnt=6 while locked: one code_err, then relock.
    n_err_seen = 0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit_j(1'b0, 2, OVS);
    check_eq("s_err_unlocked", {31'd0, locked}, 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check_eq("s_err_relock", {31'd0, locked}, 32'd1);
    idle(20);
    check_eq("s_err_count", 32'(n_err_seen), 32'd1);

    // Jitter: mid edges at cnt=7 and cnt=9 accepted, cnt=10 rejected.
    n_err_seen = 0;
    send_bit(1'b0); send_bit(1'b1);
    obs_bits.delete();
    send_bit_j(1'b0, OVS - 1, OVS);
    send_bit_j(1'b1, OVS + 1, OVS);
    check_eq("s_jit_bits", pack_bits(), 32'b01);
    check_eq("s_jit_count", 32'(obs_bits.size()), 32'd2);
    send_bit_j(1'b0, OVS + 2, OVS);
    check_eq("s_jit_err", 32'(n_err_seen), 32'd1);
    idle(20);

    // One-cycle glitch followed by a rise one bit period after its trailing edge.
    obs_bits.delete();
    n_err_seen = 0;
    step(1'b1, 1'b1);
    idle(2 * OVS);
    check_eq("s_glitch_quiet", 32'(obs_bits.size()) + 32'(n_err_seen), 32'd0);
    send_half(1'b1, OVS);
`ifdef MANCH_DEC_GLITCH_FILTER_EN
    check_eq("s_glitch_lock", {31'd0, locked}, 32'd0);
`else
    check_eq("s_glitch_lock", {31'd0, locked}, 32'd1);
`endif
    idle(20);

    // Reset mid-frame drops lock immediately.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("s_midreset_unlock", {31'd0, locked}, 32'd0);
    idle(20);

    // Randomised frames, jitter, glitches, gaps and resets.
    for (int it = 0; it < 300; it++) begin
      int unsigned r = $urandom_range(0, 99);
      if (r < 72)       send_bit_j(1'($urandom_range(0, 1)), jit(), jit());
      else if (r < 82)  step(~last_v, 1'b1);
      else if (r < 95)  idle(int'($urandom_range(10, 25)));
      else begin
        step(last_v, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
